button_reader: RTL and testbench



---
 rtl/button_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/button_reader.sv | 150 +++++++++++++++
 tb/tb_button_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constant helpers for the push-button reader.
package button_pkg;

  localparam int unsigned DURATION_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPressDeb,
    StHeld,
    StReleaseDeb
  } btn_state_e;

  // Clamped to 1 so sub-kHz clocks still produce a valid millisecond tick.
  function automatic int unsigned cyc_per_ms(input int unsigned clock_freq);
    return (clock_freq / 1000 == 0) ? 1 : clock_freq / 1000;
  endfunction

  function automatic int unsigned deb_count(input int unsigned clock_freq,
                                            input int unsigned debounce_ms);
    return (debounce_ms == 0) ? 1 : cyc_per_ms(clock_freq) * debounce_ms;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with configurable reset level.
module sync_2ff #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: press/release/long-press strobes and press duration in ms.
module button_reader
  import button_pkg::*;
#(
  parameter int unsigned clock_freq    = 12_000_000,
  parameter int unsigned debounce_ms   = 10,
  parameter int unsigned long_press_ms = 1000,
  parameter bit          active_low    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  button,
  output logic                  pressed,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic                  long_pulse,
  output logic [DURATION_W-1:0] duration_ms
);

  localparam int unsigned CycPerMs = cyc_per_ms(clock_freq);
  localparam int unsigned DebCount = deb_count(clock_freq, debounce_ms);
  localparam int unsigned PreW     = cnt_width(CycPerMs);
  localparam int unsigned DebW     = cnt_width(DebCount);

  localparam logic [PreW-1:0]       PreMax = PreW'(CycPerMs - 1);
  localparam logic [DebW-1:0]       DebMax = DebW'(DebCount - 1);
  localparam logic [DURATION_W-1:0] LongMs = DURATION_W'(long_press_ms);

  logic sync_out, btn_s;

  sync_2ff #(
    .Width     (1),
    .ResetValue(active_low)
  ) u_sync (
    .clk_i (clock),
    .rst_ni(reset_n),
    .d_i   (button),
    .q_o   (sync_out)
  );

  assign btn_s = sync_out ^ active_low;

  btn_state_e            state_q, state_d;
  logic [DebW-1:0]       deb_q, deb_d;
  logic [PreW-1:0]       pre_q, pre_d;
  logic [DURATION_W-1:0] ms_q, ms_d, ms_inc;
  logic [DURATION_W-1:0] dur_q, dur_d;
  logic                  pressed_q, pressed_d;
  logic                  press_q, press_d;
  logic                  rel_q, rel_d;
  logic                  long_q, long_d;
  logic                  ms_wrap, ms_sat;

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    pre_d     = pre_q;
    ms_d      = ms_q;
    dur_d     = dur_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;

    ms_wrap = (pre_q == PreMax);
    ms_sat  = (ms_q == '1);
    ms_inc  = (ms_wrap && !ms_sat) ? ms_q + 1'b1 : ms_q;

    // The ms clock runs for the whole press, including release debounce.
    if (state_q inside {StHeld, StReleaseDeb}) begin
      pre_d  = ms_wrap ? '0 : pre_q + 1'b1;
      ms_d   = ms_inc;
      long_d = ms_wrap && !ms_sat && (ms_inc == LongMs);
    end

    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressDeb;
          deb_d   = '0;
        end
      end
      StPressDeb: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (deb_q == DebMax) begin
          state_d   = StHeld;
          pressed_d = 1'b1;
          press_d   = 1'b1;
          ms_d      = '0;
          pre_d     = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StReleaseDeb;
          deb_d   = '0;
        end
      end
      StReleaseDeb: begin
        if (btn_s) begin
          state_d = StHeld;
        end else if (deb_q == DebMax) begin
          state_d   = StIdle;
          pressed_d = 1'b0;
          rel_d     = 1'b1;
          // Release strobe wins so no two strobes share a cycle.
          long_d    = 1'b0;
          dur_d     = ms_inc;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      deb_q     <= '0;
      pre_q     <= '0;
      ms_q      <= '0;
      dur_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      dur_q     <= dur_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign duration_ms   = dur_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: debounce, pulses, long press, reset abort, saturation.
module tb_button_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        button, button2;
  logic        pressed, press_pulse, release_pulse, long_pulse;
  logic        pressed2, press_pulse2, release_pulse2, long_pulse2;
  logic [15:0] duration_ms, duration_ms2;

  always #5 clock = ~clock;

  button_reader #(
    .clock_freq   (10_000),
    .debounce_ms  (2),
    .long_press_ms(5),
    .active_low   (1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .button       (button),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .duration_ms  (duration_ms)
  );

  // 1 cycle per ms and zero debounce: exercises saturation and the forced DEB_COUNT of 1.
  button_reader #(
    .clock_freq   (1000),
    .debounce_ms  (0),
    .long_press_ms(5),
    .active_low   (1'b1)
  ) dut2 (
    .clock        (clock),
    .reset_n      (reset_n),
    .button       (button2),
    .pressed      (pressed2),
    .press_pulse  (press_pulse2),
    .release_pulse(release_pulse2),
    .long_pulse   (long_pulse2),
    .duration_ms  (duration_ms2)
  );

  int unsigned n_vec = 0, n_bad = 0;
  int unsigned cyc = 0;

  int unsigned n_press = 0, n_rel = 0, n_long = 0, n_ovl = 0;
  int unsigned t_press = 0, t_rel = 0, t_long = 0;
  int unsigned n2_press = 0, n2_rel = 0, n2_long = 0, n2_ovl = 0;
  int unsigned t2_press = 0, t2_rel = 0, t2_long = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Timestamp strobes #1 after the edge (cyc already updated).
  always @(posedge clock) begin
    #1;
    if (press_pulse)   begin n_press++; t_press = cyc; end
    if (release_pulse) begin n_rel++;   t_rel   = cyc; end
    if (long_pulse)    begin n_long++;  t_long  = cyc; end
    if ($countones({press_pulse, release_pulse, long_pulse}) > 1) n_ovl++;
    if (press_pulse2)   begin n2_press++; t2_press = cyc; end
    if (release_pulse2) begin n2_rel++;   t2_rel   = cyc; end
    if (long_pulse2)    begin n2_long++;  t2_long  = cyc; end
    if ($countones({press_pulse2, release_pulse2, long_pulse2}) > 1) n2_ovl++;
  end

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int unsigned t0, t1, tr, p0, r0, l0;
    logic seen;

    reset_n = 1'b0;
    button  = 1'b1;
    button2 = 1'b1;
    wait_neg(3);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'd0);
    check("rst_duration", 32'(duration_ms), 32'd0);
    check("rst_pressed2", 32'(pressed2), 32'd0);
    reset_n = 1'b1;
    wait_neg(5);

    // 1: clean 200-cycle press -> 20 ms
    p0 = n_press; r0 = n_rel; l0 = n_long;
    t0 = cyc; button = 1'b0;
    wait_neg(200);
    check("t1_press_time", t_press, t0 + 23);
    check("t1_press_cnt", n_press - p0, 32'd1);
    check("t1_pressed", 32'(pressed), 32'd1);
    t1 = cyc; button = 1'b1;
    wait_neg(30);
    check("t1_release_time", t_rel, t1 + 23);
    check("t1_release_cnt", n_rel - r0, 32'd1);
    check("t1_released", 32'(pressed), 32'd0);
    check("t1_duration", 32'(duration_ms), 32'd20);
    check("t1_long_cnt", n_long - l0, 32'd1);

    // 2: bounce shorter than the debounce window is rejected
    p0 = n_press; r0 = n_rel; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 20; j++) begin
        button = (j < 15) ? 1'b0 : 1'b1;
        @(negedge clock);
        seen = seen | pressed;
      end
    end
    button = 1'b1;
    wait_neg(30);
    check("t2_pressed_seen", 32'(seen), 32'd0);
    check("t2_press_cnt", n_press - p0, 32'd0);
    check("t2_release_cnt", n_rel - r0, 32'd0);
    check("t2_duration_held", 32'(duration_ms), 32'd20);

    // 3: 100-cycle press -> long strobe 50 cycles after press, 10 ms
    l0 = n_long;
    t0 = cyc; button = 1'b0;
    wait_neg(100);
    t1 = cyc; button = 1'b1;
    wait_neg(30);
    check("t3_long_cnt", n_long - l0, 32'd1);
    check("t3_long_time", t_long, t0 + 23 + 50);
    check("t3_release_time", t_rel, t1 + 23);
    check("t3_duration", 32'(duration_ms), 32'd10);

    // 4: release bounce while held; ms keeps counting through it
    r0 = n_rel; l0 = n_long;
    t0 = cyc; button = 1'b0;
    wait_neg(30);
    button = 1'b1;
    wait_neg(10);
    button = 1'b0;
    wait_neg(20);
    check("t4_pressed_bounce", 32'(pressed), 32'd1);
    check("t4_no_release", n_rel - r0, 32'd0);
    wait_neg(70);
    t1 = cyc; button = 1'b1;
    wait_neg(30);
    check("t4_release_cnt", n_rel - r0, 32'd1);
    check("t4_long_cnt", n_long - l0, 32'd1);
    check("t4_duration", 32'(duration_ms), 32'd13);

    // 5: reset 30 cycles into HELD aborts the press
    t0 = cyc; button = 1'b0;
    wait_neg(53);
    check("t5_held", 32'(pressed), 32'd1);
    r0 = n_rel;
    reset_n = 1'b0;
    #1;
    check("t5_rst_pressed", 32'(pressed), 32'd0);
    check("t5_rst_pulses", 32'({press_pulse, release_pulse, long_pulse}), 32'd0);
    check("t5_rst_duration", 32'(duration_ms), 32'd0);
    wait_neg(3);
    p0 = n_press;
    tr = cyc; reset_n = 1'b1;
    wait_neg(30);
    check("t5_press_cnt", n_press - p0, 32'd1);
    check("t5_press_time", t_press, tr + 23);
    check("t5_no_release", n_rel - r0, 32'd0);
    t1 = cyc; button = 1'b1;
    wait_neg(30);
    check("t5_duration", 32'(duration_ms), 32'd3);

    // 6: saturation on dut2 (1 cycle per ms)
    t0 = cyc; button2 = 1'b0;
    wait_neg(20);
    check("t6_press_time", t2_press, t0 + 4);
    check("t6_long_time", t2_long, t0 + 4 + 5);
    wait_neg(65580);
    check("t6_pressed", 32'(pressed2), 32'd1);
    t1 = cyc; button2 = 1'b1;
    wait_neg(10);
    check("t6_release_time", t2_rel, t1 + 4);
    check("t6_duration_sat", 32'(duration_ms2), 32'h0000_FFFF);
    check("t6_long_cnt", n2_long, 32'd1);

    check("overlap", n_ovl, 32'd0);
    check("overlap2", n2_ovl, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
